// File: rtl/cnn_pkg.sv
// Shared types and sizes for the CNN run sequencer: FSM state encoding,
// command mode encodings, BRAM port select and default array sizes.
package cnn_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_DATA = 3'd1,
        S_LOAD_KW   = 3'd2,
        S_LOAD_DW   = 3'd3,
        S_START     = 3'd4,
        S_WAIT_DONE = 3'd5,
        S_SETTLE    = 3'd6,
        S_REPORT    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        SEL_DATA = 2'd0,
        SEL_KW   = 2'd1,
        SEL_DW   = 2'd2
    } bram_sel_t;

    localparam logic [1:0] MODE_FULL  = 2'd0;
    localparam logic [1:0] MODE_DENSE = 2'd1;
    localparam logic [1:0] MODE_RUN   = 2'd2;
    localparam logic [1:0] MODE_RSVD  = 2'd3;

    localparam int DEF_N_DATA  = 8;
    localparam int DEF_N_KW    = 3;
    localparam int DEF_N_DW    = 18;
    localparam int DEF_TIMEOUT = 1024;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cnn_run_sequencer_if.sv
// Bundle of command, load, BRAM write, cnn_top and result signals around
// the run sequencer. slave = sequencer side, master = host/testbench side.
interface cnn_run_sequencer_if #(
    parameter int CONV_DATA_W    = 8,
    parameter int CONV_ADDR_W    = 4,
    parameter int DENSE_WEIGHT_W = 8,
    parameter int DENSE_ADDR_W   = 5
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [1:0]                cmd_mode;
    logic [1:0]                cmd_expected;
    logic                      ld_valid;
    logic                      ld_ready;
    logic [7:0]                ld_data;
    logic                      data_bram_wen;
    logic [CONV_ADDR_W-1:0]    data_bram_addr;
    logic [CONV_DATA_W-1:0]    data_bram_din;
    logic                      weight_bram_wen;
    logic [CONV_ADDR_W-1:0]    weight_bram_addr;
    logic [CONV_DATA_W-1:0]    weight_bram_din;
    logic                      dense_w_bram_wen;
    logic [DENSE_ADDR_W-1:0]   dense_w_bram_addr;
    logic [DENSE_WEIGHT_W-1:0] dense_w_bram_din;
    logic                      cnn_start;
    logic                      cnn_done;
    logic [1:0]                cnn_class;
    logic                      busy;
    logic                      result_valid;
    logic [1:0]                result_class;
    logic                      result_pass;
    logic                      result_timeout;

    modport slave (
        input  cmd_valid, cmd_mode, cmd_expected, ld_valid, ld_data, cnn_done, cnn_class,
        output cmd_ready, ld_ready,
        output data_bram_wen, data_bram_addr, data_bram_din,
        output weight_bram_wen, weight_bram_addr, weight_bram_din,
        output dense_w_bram_wen, dense_w_bram_addr, dense_w_bram_din,
        output cnn_start, busy, result_valid, result_class, result_pass, result_timeout
    );

    modport master (
        output cmd_valid, cmd_mode, cmd_expected, ld_valid, ld_data, cnn_done, cnn_class,
        input  cmd_ready, ld_ready,
        input  data_bram_wen, data_bram_addr, data_bram_din,
        input  weight_bram_wen, weight_bram_addr, weight_bram_din,
        input  dense_w_bram_wen, dense_w_bram_addr, dense_w_bram_din,
        input  cnn_start, busy, result_valid, result_class, result_pass, result_timeout
    );

endinterface

// File: rtl/cnn_bram_load_mux.sv
// Registers one load beat (strobe, address, data) and steers the one-cycle
// write strobe to the selected BRAM port. Address/data are shared by all
// three ports; only the strobe is port specific.
module cnn_bram_load_mux
    import cnn_pkg::*;
#(
    parameter int CONV_DATA_W    = 8,
    parameter int CONV_ADDR_W    = 4,
    parameter int DENSE_WEIGHT_W = 8,
    parameter int DENSE_ADDR_W   = 5,
    parameter int IDX_W          = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_wr,
    input  bram_sel_t                 i_sel,
    input  logic [IDX_W-1:0]          i_addr,
    input  logic [7:0]                i_data,
    output logic                      o_data_wen,
    output logic [CONV_ADDR_W-1:0]    o_data_addr,
    output logic [CONV_DATA_W-1:0]    o_data_din,
    output logic                      o_kw_wen,
    output logic [CONV_ADDR_W-1:0]    o_kw_addr,
    output logic [CONV_DATA_W-1:0]    o_kw_din,
    output logic                      o_dw_wen,
    output logic [DENSE_ADDR_W-1:0]   o_dw_addr,
    output logic [DENSE_WEIGHT_W-1:0] o_dw_din
);
    localparam int ADR_W = max2(IDX_W, max2(CONV_ADDR_W, DENSE_ADDR_W));
    localparam int DIN_W = max2(8, max2(CONV_DATA_W, DENSE_WEIGHT_W));

    logic             r_wen_data;
    logic             r_wen_kw;
    logic             r_wen_dw;
    logic [ADR_W-1:0] r_addr;
    logic [DIN_W-1:0] r_din;

    // Capture an accepted beat; strobe lasts exactly one cycle, addr/din hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen_data <= 1'b0;
            r_wen_kw   <= 1'b0;
            r_wen_dw   <= 1'b0;
            r_addr     <= '0;
            r_din      <= '0;
        end else begin
            r_wen_data <= i_wr && (i_sel == SEL_DATA);
            r_wen_kw   <= i_wr && (i_sel == SEL_KW);
            r_wen_dw   <= i_wr && (i_sel == SEL_DW);
            if (i_wr) begin
                r_addr <= ADR_W'(i_addr);
                r_din  <= DIN_W'(i_data);
            end
        end
    end

    assign o_data_wen  = r_wen_data;
    assign o_data_addr = r_addr[CONV_ADDR_W-1:0];
    assign o_data_din  = r_din[CONV_DATA_W-1:0];
    assign o_kw_wen    = r_wen_kw;
    assign o_kw_addr   = r_addr[CONV_ADDR_W-1:0];
    assign o_kw_din    = r_din[CONV_DATA_W-1:0];
    assign o_dw_wen    = r_wen_dw;
    assign o_dw_addr   = r_addr[DENSE_ADDR_W-1:0];
    assign o_dw_din    = r_din[DENSE_WEIGHT_W-1:0];

endmodule

// File: rtl/cnn_run_sequencer.sv
// Run sequencer for cnn_top: accepts a command, streams load words into the
// conv data / conv kernel / dense weight BRAMs, pulses cnn_start, waits for
// done (with timeout) and reports the captured class.
module cnn_run_sequencer
    import cnn_pkg::*;
#(
    parameter int CONV_DATA_W    = 8,
    parameter int CONV_ADDR_W    = 4,
    parameter int DENSE_WEIGHT_W = 8,
    parameter int DENSE_ADDR_W   = 5,
    parameter int N_DATA         = DEF_N_DATA,
    parameter int N_KW           = DEF_N_KW,
    parameter int N_DW           = DEF_N_DW,
    parameter int TIMEOUT        = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    cnn_run_sequencer_if.slave bus
);
    localparam int IDX_W = max2(CONV_ADDR_W, DENSE_ADDR_W);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic             r_drain;
    logic [1:0]       r_exp;
    logic [1:0]       r_class;
    logic             r_pass;
    logic             r_timeout;

    logic             w_cmd_ready;
    logic             w_ld_ready;
    logic             w_start;
    logic             w_busy;
    logic             w_res_valid;
    logic             w_last;
    bram_sel_t        w_sel;
    logic             w_cmd_hs;
    logic             w_ld_hs;
    logic             w_timeout;

    assign w_cmd_hs  = w_cmd_ready && bus.cmd_valid;
    assign w_ld_hs   = w_ld_ready && bus.ld_valid;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic. LOAD_DW lingers one drain cycle after its last beat so
    // the final write strobe completes before START.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_mode == MODE_FULL)       w_next = S_LOAD_DATA;
                    else if (bus.cmd_mode == MODE_DENSE) w_next = S_LOAD_DW;
                    else if (bus.cmd_mode == MODE_RUN)   w_next = S_START;
                    else                                 w_next = S_REPORT;
                end
            end
            S_LOAD_DATA: if (w_ld_hs && w_last) w_next = S_LOAD_KW;
            S_LOAD_KW:   if (w_ld_hs && w_last) w_next = S_LOAD_DW;
            S_LOAD_DW:   if (r_drain) w_next = S_START;
            S_START:     w_next = S_WAIT_DONE;
            S_WAIT_DONE: begin
                if (bus.cnn_done)   w_next = S_SETTLE;
                else if (w_timeout) w_next = S_REPORT;
            end
            S_SETTLE:    w_next = S_REPORT;
            S_REPORT:    w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    // State-decoded outputs, port select and last-beat detection.
    always_comb begin
        w_cmd_ready = 1'b0;
        w_ld_ready  = 1'b0;
        w_start     = 1'b0;
        w_busy      = 1'b1;
        w_res_valid = 1'b0;
        w_last      = 1'b0;
        w_sel       = SEL_DATA;
        unique case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                w_busy      = 1'b0;
            end
            S_LOAD_DATA: begin
                w_ld_ready = 1'b1;
                w_sel      = SEL_DATA;
                w_last     = (r_idx == IDX_W'(N_DATA - 1));
            end
            S_LOAD_KW: begin
                w_ld_ready = 1'b1;
                w_sel      = SEL_KW;
                w_last     = (r_idx == IDX_W'(N_KW - 1));
            end
            S_LOAD_DW: begin
                w_ld_ready = !r_drain;
                w_sel      = SEL_DW;
                w_last     = (r_idx == IDX_W'(N_DW - 1));
            end
            S_START:  w_start     = 1'b1;
            S_REPORT: w_res_valid = 1'b1;
            default:  w_busy      = 1'b1;
        endcase
    end

    // Beat index, done-wait counter, latched command and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_cnt     <= '0;
            r_drain   <= 1'b0;
            r_exp     <= 2'd0;
            r_class   <= 2'd0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            if (w_cmd_hs) begin
                r_exp <= bus.cmd_expected;
                if (bus.cmd_mode == MODE_RSVD) begin
                    r_class   <= 2'd0;
                    r_pass    <= 1'b0;
                    r_timeout <= 1'b0;
                end
            end
            if (w_ld_hs) begin
                r_idx <= w_last ? '0 : r_idx + 1'b1;
                if (w_last && r_state == S_LOAD_DW) r_drain <= 1'b1;
            end
            if (r_state == S_LOAD_DW && r_drain) r_drain <= 1'b0;
            r_cnt <= (r_state == S_WAIT_DONE) ? r_cnt + 1'b1 : '0;
            if (r_state == S_WAIT_DONE && !bus.cnn_done && w_timeout) begin
                r_class   <= 2'd0;
                r_pass    <= 1'b0;
                r_timeout <= 1'b1;
            end
            if (r_state == S_SETTLE) begin
                r_class   <= bus.cnn_class;
                r_pass    <= (bus.cnn_class == r_exp);
                r_timeout <= 1'b0;
            end
        end
    end

    cnn_bram_load_mux #(
        .CONV_DATA_W    (CONV_DATA_W),
        .CONV_ADDR_W    (CONV_ADDR_W),
        .DENSE_WEIGHT_W (DENSE_WEIGHT_W),
        .DENSE_ADDR_W   (DENSE_ADDR_W),
        .IDX_W          (IDX_W)
    ) u_load_mux (
        .clk         (clk),
        .rst         (rst),
        .i_wr        (w_ld_hs),
        .i_sel       (w_sel),
        .i_addr      (r_idx),
        .i_data      (bus.ld_data),
        .o_data_wen  (bus.data_bram_wen),
        .o_data_addr (bus.data_bram_addr),
        .o_data_din  (bus.data_bram_din),
        .o_kw_wen    (bus.weight_bram_wen),
        .o_kw_addr   (bus.weight_bram_addr),
        .o_kw_din    (bus.weight_bram_din),
        .o_dw_wen    (bus.dense_w_bram_wen),
        .o_dw_addr   (bus.dense_w_bram_addr),
        .o_dw_din    (bus.dense_w_bram_din)
    );

    assign bus.cmd_ready      = w_cmd_ready;
    assign bus.ld_ready       = w_ld_ready;
    assign bus.cnn_start      = w_start;
    assign bus.busy           = w_busy;
    assign bus.result_valid   = w_res_valid;
    assign bus.result_class   = r_class;
    assign bus.result_pass    = r_pass;
    assign bus.result_timeout = r_timeout;

endmodule

// File: doc/cnn_run_sequencer.md
CNN_RUN_SEQUENCER -- requirements
Module: cnn_run_sequencer

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- CONV_DATA_W, 8, conv data/weight word width
- CONV_ADDR_W, 4, conv BRAM address width
- DENSE_WEIGHT_W, 8, dense weight width
- DENSE_ADDR_W, 5, dense weight BRAM address width
- N_DATA, 8, conv input samples
- N_KW, 3, conv kernel taps
- N_DW, 18, dense weights (6 features x 3 classes)
- TIMEOUT, 1024, maximum wait cycles for done
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- rst, in, 1, synchronous active-high reset
- cmd_valid, in, 1, command request
- cmd_ready, out, 1, command accepted
- cmd_mode, in, 2, 0 = full load+run, 1 = dense-weights load+run, 2 = run only, 3 = reserved
- cmd_expected, in, 2, expected class
- ld_valid, in, 1, load word valid
- ld_ready, out, 1, load word accepted
- ld_data, in, 8, load word
- data_bram_wen / addr / din, out, 1 / CONV_ADDR_W / CONV_DATA_W, conv data write port
- weight_bram_wen / addr / din, out, 1 / CONV_ADDR_W / CONV_DATA_W, conv kernel write port
- dense_w_bram_wen / addr / din, out, 1 / DENSE_ADDR_W / DENSE_WEIGHT_W, dense weight write port
- cnn_start, out, 1, start pulse to cnn_top
- cnn_done, in, 1, cnn_top done
- cnn_class, in, 2, cnn_top final class
- busy, out, 1, not IDLE
- result_valid, out, 1, one-cycle result strobe
- result_class, out, 2, captured class
- result_pass, out, 1, class matches expected
- result_timeout, out, 1, done never seen

Function
REQ-003 SHALL implement states IDLE, LOAD_DATA, LOAD_KW, LOAD_DW, START, WAIT_DONE, SETTLE, REPORT.
REQ-004 cmd_ready SHALL be high only in IDLE; a handshake latches cmd_mode and cmd_expected. Mode 0 goes to LOAD_DATA, mode 1 to LOAD_DW, mode 2 to START. Mode 3 SHALL be accepted and go straight to REPORT with result_pass=0 and result_timeout=0.
REQ-005 ld_ready SHALL be high only in the LOAD_* states.
REQ-006 Each ld handshake SHALL write the word to the active port on the next cycle: wen=1 for exactly one cycle, addr = beat index, din = ld_data truncated or zero-extended to the port width. wen SHALL be 0 otherwise.
REQ-007 Beat index SHALL start at 0 in each LOAD state. On the last beat (N_DATA-1, N_KW-1 or N_DW-1) the state SHALL advance: LOAD_DATA to LOAD_KW to LOAD_DW to START. The index SHALL never exceed the last beat.
REQ-008 ld_valid stalls SHALL hold state and index; no write occurs on a stalled cycle.
REQ-009 START SHALL last exactly one cycle with cnn_start=1; cnn_start SHALL be 0 in every other state. START is entered only after the final write's wen cycle has completed.
REQ-010 In WAIT_DONE, a cycle counter SHALL start at 0 and increment each cycle.
- cnn_done=1 SHALL move to SETTLE.
- When the counter reaches TIMEOUT-1 without done, the state SHALL move to REPORT with result_timeout=1 and result_class=0.
- Done in the same cycle as the timeout SHALL count as done.
REQ-011 cnn_done SHALL be ignored in IDLE, LOAD_* and START.
REQ-012 SETTLE SHALL last one cycle and capture cnn_class on its clock edge (one cycle after done is seen). result_pass = (captured class == cmd_expected).
REQ-013 REPORT SHALL pulse result_valid for one cycle and then return to IDLE. result_class, result_pass and result_timeout SHALL hold until the next REPORT.
REQ-014 Latency: a mode 2 command accepted at cycle t gives cnn_start at t+1.

Reset
REQ-015 rst SHALL be synchronous, take priority over every other input, and may be asserted in any state, including mid-load and WAIT_DONE.
REQ-016 On reset: state IDLE; all wen, cnn_start and result_valid = 0; all addr, din and counters = 0; busy=0; result_class=0; result_pass=0; result_timeout=0. No write or start SHALL be issued in the cycle after reset is released.

Structure
REQ-017 A shared package cnn_pkg SHALL hold the state encoding, the cmd_mode encodings, and the default sizes N_DATA, N_KW, N_DW and TIMEOUT.
REQ-018 A single sub-module cnn_bram_load_mux SHALL register the one-cycle write strobe, address and data, and steer them to one of the three ports.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Mode 0, data [1,0,1,0,1,0,1,0], kernel [1,2,1], dense weights 5x6 then 1x12, expected 0, DUT model answers 0: exactly 29 writes with correct addr/din, one cnn_start pulse, result_valid with result_class=0 and result_pass=1.
- Mode 1, 18 weights favouring class 1, expected 1: no conv writes, 18 dense writes, result_pass=1. Repeat for class 2 with expected=1: result_pass=0 and result_class=2.
- Random ld_valid gaps, 50% duty: written contents identical to the no-stall case, and wen never high on a stall cycle.
- Mode 2 with done held low: result_timeout=1 and result_valid exactly TIMEOUT cycles after WAIT_DONE entry. With done high during START only: done is ignored and the run still times out.
- rst asserted at data beat 4 and again in WAIT_DONE: outputs match REQ-016 on the next cycle, and a following mode 2 command completes normally.
